// File: rtl/syn_pkg.sv
// Shared types and arithmetic helpers for the synapse pulse shaper.
// Optional drop counting is enabled by defining SYN_DROP_CNT_EN.
package syn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    DECAY   = 2'd2,
    REFRACT = 2'd3
  } synState_e;

  localparam int MAX_AMP_W = 32;
  localparam int DROP_W    = 8;

  // Helpers work at a fixed maximum width; callers cast to their own amplitude width.
  function automatic logic [MAX_AMP_W-1:0] sat_add(input logic [MAX_AMP_W-1:0] a,
                                                   input logic [MAX_AMP_W-1:0] b,
                                                   input int unsigned width);
    logic [MAX_AMP_W:0] sum;
    logic [MAX_AMP_W:0] limit;
    sum   = {1'b0, a} + {1'b0, b};
    limit = ((MAX_AMP_W+1)'(1) << width) - (MAX_AMP_W+1)'(1);
    if (sum > limit) begin
      return limit[MAX_AMP_W-1:0];
    end
    return sum[MAX_AMP_W-1:0];
  endfunction

  function automatic logic [MAX_AMP_W-1:0] decay_step(input logic [MAX_AMP_W-1:0] amp,
                                                      input int unsigned shift);
    logic [MAX_AMP_W-1:0] step;
    step = amp >> shift;
    if (step == '0) begin
      step = MAX_AMP_W'(1);
    end
    if (amp < step) begin
      return '0;
    end
    return amp - step;
  endfunction

endpackage

// File: rtl/synapse_channel.sv
// One synapse channel: IDLE/HOLD/DECAY/REFRACT FSM, amplitude and counter.
// With SYN_DROP_CNT_EN defined, also counts ignored fires in a saturating 8-bit counter.
module synapse_channel
  import syn_pkg::*;
#(
  parameter int AMP_W        = 8,
  parameter int HOLD_TIME    = 8,
  parameter int DECAY_SHIFT  = 2,
  parameter int REFRACT_TIME = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fire_i,
  input  logic [AMP_W-1:0] weight_i,
  input  logic             retrig_en_i,
  output logic             active_o,
  output logic [AMP_W-1:0] amp_o
`ifdef SYN_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] dropCnt_o
`endif
);

  localparam int MAX_T = (HOLD_TIME > REFRACT_TIME) ? HOLD_TIME : REFRACT_TIME;
  localparam int CTR_W = $clog2(MAX_T + 1);
  localparam logic [CTR_W-1:0] HOLD_INIT = CTR_W'(HOLD_TIME - 1);
  localparam logic [CTR_W-1:0] REFR_INIT = (REFRACT_TIME > 0) ? CTR_W'(REFRACT_TIME - 1) : '0;

  synState_e        state_q, state_d;
  logic [AMP_W-1:0] amp_q, amp_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             active_q;

  logic [AMP_W-1:0] ampAdd;
  logic [AMP_W-1:0] ampDec;
  synState_e        decayState;
  logic [CTR_W-1:0] decayCtr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      amp_q    <= '0;
      ctr_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      amp_q    <= amp_d;
      ctr_q    <= ctr_d;
      active_q <= (amp_d != '0);
    end
  end

  // A decay step that reaches zero leaves DECAY; otherwise the channel keeps decaying.
  always_comb begin
    ampAdd     = AMP_W'(sat_add(MAX_AMP_W'(amp_q), MAX_AMP_W'(weight_i), AMP_W));
    ampDec     = AMP_W'(decay_step(MAX_AMP_W'(amp_q), DECAY_SHIFT));
    decayState = DECAY;
    decayCtr   = ctr_q;
    if (ampDec == '0) begin
      if (REFRACT_TIME > 0) begin
        decayState = REFRACT;
        decayCtr   = REFR_INIT;
      end else begin
        decayState = IDLE;
        decayCtr   = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    ctr_d   = ctr_q;
    unique case (state_q)
      IDLE: begin
        if (fire_i && (weight_i != '0)) begin
          state_d = HOLD;
          amp_d   = weight_i;
          ctr_d   = HOLD_INIT;
        end
      end
      HOLD, DECAY: begin
        if (fire_i && retrig_en_i) begin
          state_d = HOLD;
          amp_d   = ampAdd;
          ctr_d   = HOLD_INIT;
        end else if ((state_q == HOLD) && (ctr_q != '0)) begin
          ctr_d = ctr_q - CTR_W'(1);
        end else begin
          state_d = decayState;
          amp_d   = ampDec;
          ctr_d   = decayCtr;
        end
      end
      REFRACT: begin
        amp_d = '0;
        if (ctr_q == '0) begin
          state_d = IDLE;
        end else begin
          ctr_d = ctr_q - CTR_W'(1);
        end
      end
    endcase
  end

  assign active_o = active_q;
  assign amp_o    = amp_q;

`ifdef SYN_DROP_CNT_EN
  logic              dropEvent;
  logic [DROP_W-1:0] dropCnt_q;

  assign dropEvent = fire_i && ((state_q == REFRACT) ||
                     (((state_q == HOLD) || (state_q == DECAY)) && !retrig_en_i));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropCnt_q <= '0;
    end else if (dropEvent && (dropCnt_q != {DROP_W{1'b1}})) begin
      dropCnt_q <= dropCnt_q + DROP_W'(1);
    end
  end

  assign dropCnt_o = dropCnt_q;
`endif

endmodule

// File: rtl/synapse_pulse_shaper.sv
// Multi-channel synaptic pulse shaper with a registered sum for the membrane integrator.
// Defining SYN_DROP_CNT_EN adds the per-channel drop_cnt output.
module synapse_pulse_shaper
  import syn_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int AMP_W        = 8,
  parameter int HOLD_TIME    = 8,
  parameter int DECAY_SHIFT  = 2,
  parameter int REFRACT_TIME = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_CH-1:0]                fire,
  input  logic [N_CH*AMP_W-1:0]          weight,
  input  logic                           retrig_en,
  output logic [N_CH-1:0]                syn_out,
  output logic [N_CH*AMP_W-1:0]          syn_amp,
  output logic [AMP_W+$clog2(N_CH)-1:0]  syn_sum
`ifdef SYN_DROP_CNT_EN
  ,
  output logic [N_CH*DROP_W-1:0]         drop_cnt
`endif
);

  localparam int SUM_W = AMP_W + $clog2(N_CH);

  logic [SUM_W-1:0] sum_d;
  logic [SUM_W-1:0] sum_q;

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    synapse_channel #(
      .AMP_W       (AMP_W),
      .HOLD_TIME   (HOLD_TIME),
      .DECAY_SHIFT (DECAY_SHIFT),
      .REFRACT_TIME(REFRACT_TIME)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .fire_i     (fire[g]),
      .weight_i   (weight[g*AMP_W +: AMP_W]),
      .retrig_en_i(retrig_en),
      .active_o   (syn_out[g]),
      .amp_o      (syn_amp[g*AMP_W +: AMP_W])
`ifdef SYN_DROP_CNT_EN
      ,
      .dropCnt_o  (drop_cnt[g*DROP_W +: DROP_W])
`endif
    );
  end

  // The sum is taken from the registered amplitudes, so it trails syn_amp by one cycle.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      sum_d = sum_d + SUM_W'(syn_amp[i*AMP_W +: AMP_W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign syn_sum = sum_q;

endmodule
